instr_fetch: RTL and testbench

- PC generator and fetch buffer sitting directly upstream of instr_mem and downstream-feeding the decode stage.
- Drives a 16-bit byte address to instr_mem, captures the combinationally returned 16-bit instruction, and queues {pc, instr} pairs in a small FIFO.
- Presents queued pairs to decode over a valid/ready handshake.
- Handles branch/jump redirects, back-pressure and halt on a zero instruction word.

---
 rtl/instr_fetch.sv | 139 +++++++++++++
 tb/tb_instr_fetch.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: PC generator and small fetch FIFO feeding decode, with redirect and halt-on-zero.
// Define FETCH_PERF_CNT_EN to enable the saturating fetch_count counter; otherwise it reads 0.
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned PC_STEP  = 2,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imem_pc,
  input  logic [15:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_pc,
  output logic [15:0] out_instr,
  output logic        halted,
  output logic [15:0] fetch_count
);

  localparam int unsigned AW        = (DEPTH > 2) ? 2 : 1;
  localparam logic [AW:0] C_FULL    = DEPTH[AW:0];
  localparam logic [15:0] C_PC_STEP = PC_STEP[15:0];

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HALT  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [15:0]   r_pc;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [15:0]   r_fifo_pc    [DEPTH];
  logic [15:0]   r_fifo_instr [DEPTH];
  logic          w_push;
  logic          w_pop;
  logic          w_zero_word;
  logic          w_unused;

  assign w_unused    = redirect_pc[0];
  assign w_zero_word = (imem_instr == 16'h0000);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: redirect always wins and leaves HALT
  always_comb begin
    w_state_next = r_state;
    if (redirect_valid) begin
      w_state_next = S_FETCH;
    end else if (w_push && w_zero_word) begin
      w_state_next = S_HALT;
    end
  end

  // Output / control decode; a full FIFO at cycle start blocks the push even if a pop occurs
  always_comb begin
    w_push = (r_state == S_FETCH) && (r_count != C_FULL) && !redirect_valid;
    w_pop  = out_valid && out_ready && !redirect_valid;
    halted = (r_state == S_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= {redirect_pc[15:1], 1'b0};
    end else if (w_push && !w_zero_word) begin
      r_pc <= r_pc + C_PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  // Storage is reset so the head reads 0 out of reset and never carries X
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_fifo_pc[gi]    <= '0;
          r_fifo_instr[gi] <= '0;
        end else if (w_push && (r_wr_ptr == AW'(gi))) begin
          r_fifo_pc[gi]    <= r_pc;
          r_fifo_instr[gi] <= imem_instr;
        end
      end
    end
  endgenerate

  assign imem_pc   = r_pc;
  assign out_valid = (r_count != '0);
  assign out_pc    = r_fifo_pc[r_rd_ptr];
  assign out_instr = r_fifo_instr[r_rd_ptr];

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_fetch_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count <= '0;
    end else if (w_push && (r_fetch_count != 16'hFFFF)) begin
      r_fetch_count <= r_fetch_count + 16'd1;
    end
  end

  assign fetch_count = r_fetch_count;
`else
  assign fetch_count = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based reference model.
module tb_instr_fetch;

  localparam int unsigned DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic [15:0] imem_pc;
  logic [15:0] imem_instr;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_pc;
  logic [15:0] out_instr;
  logic        halted;
  logic [15:0] fetch_count;

  logic [15:0] mem [0:32767];

  int unsigned n_pass;
  int unsigned n_total;

  // Reference model state
  logic [31:0] q [$];
  logic [15:0] m_pc;
  logic        m_halted;
  logic [15:0] m_fcnt;
  logic [15:0] popped [$];

  instr_fetch #(
    .RESET_PC(16'h0000),
    .PC_STEP (2),
    .DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_pc       (imem_pc),
    .imem_instr    (imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  assign imem_instr = mem[imem_pc[15:1]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc     = 16'h0000;
    m_halted = 1'b0;
    m_fcnt   = 16'h0000;
  endtask

  task automatic model_update(input logic rv, input logic [15:0] rpc, input logic rdy);
    logic [15:0] w;
    bit          full;
    if (rv) begin
      q.delete();
      m_pc     = {rpc[15:1], 1'b0};
      m_halted = 1'b0;
    end else begin
      full = (q.size() == DEPTH);
      w    = mem[m_pc[15:1]];
      if (rdy && q.size() > 0) void'(q.pop_front());
      if (!m_halted && !full) begin
        q.push_back({m_pc, w});
        if (m_fcnt != 16'hFFFF) m_fcnt = m_fcnt + 16'd1;
        if (w == 16'h0000) m_halted = 1'b1;
        else m_pc = m_pc + 16'd2;
      end
    end
  endtask

  task automatic check_model();
    logic [31:0] head;
    logic [15:0] exp_fc;
    n_total++;
    if ($isunknown(out_valid)) begin
      $display("FAIL out_valid_x actual=%b required=known t=%0t", out_valid, $time);
    end else begin
      n_pass++;
    end
    chk("out_valid", {15'd0, out_valid}, {15'd0, (q.size() > 0)});
    if (q.size() > 0) begin
      head = q[0];
      chk("out_pc", out_pc, head[31:16]);
      chk("out_instr", out_instr, head[15:0]);
    end
    chk("imem_pc", imem_pc, m_pc);
    chk("halted", {15'd0, halted}, {15'd0, m_halted});
`ifdef FETCH_PERF_CNT_EN
    exp_fc = m_fcnt;
`else
    exp_fc = 16'h0000;
`endif
    chk("fetch_count", fetch_count, exp_fc);
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare at the falling edge
  task automatic step(input logic rv, input logic [15:0] rpc, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    if (rdy && !rv && out_valid) popped.push_back(out_pc);
    @(posedge clk);
    model_update(rv, rpc, rdy);
    @(negedge clk);
    redirect_valid = 1'b0;
    check_model();
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    out_ready      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_model();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    out_ready      = 1'b0;
    for (int i = 0; i < 32768; i++) begin
      mem[i] = 16'($urandom_range(1, 16'hFFFF));
    end
    mem[0] = 16'h1111;
    mem[1] = 16'h2222;
    mem[2] = 16'h3333;
    mem[3] = 16'h4444;

    // Reset state and streaming
    do_reset();
    chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_imem_pc", imem_pc, 16'h0000);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_fetch_count", fetch_count, 16'h0000);
    chk("rst_out_pc", out_pc, 16'h0000);
    chk("rst_out_instr", out_instr, 16'h0000);
    step(1'b0, 16'h0, 1'b1);
    chk("s1_pc", out_pc, 16'h0000);
    chk("s1_instr", out_instr, 16'h1111);
    chk("s1_imem_pc", imem_pc, 16'h0002);
    step(1'b0, 16'h0, 1'b1);
    chk("s2_pc", out_pc, 16'h0002);
    chk("s2_instr", out_instr, 16'h2222);
    chk("s2_imem_pc", imem_pc, 16'h0004);
    step(1'b0, 16'h0, 1'b1);
    chk("s3_pc", out_pc, 16'h0004);
    chk("s3_instr", out_instr, 16'h3333);
    chk("s3_imem_pc", imem_pc, 16'h0006);

    // Back-pressure
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b0);
    chk("bp_imem_pc", imem_pc, 16'h0004);
    chk("bp_out_pc", out_pc, 16'h0000);
    chk("bp_out_valid", {15'd0, out_valid}, 16'd1);
    popped.delete();
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b1);
    chk("bp_pop_count", 16'(popped.size()), 16'd4);
    for (int i = 0; i < 4 && i < popped.size(); i++) begin
      chk("bp_pop_pc", popped[i], 16'(2 * i));
    end

    // Redirect while streaming, with a same-cycle pop request
    step(1'b1, 16'h0011, 1'b1);
    chk("rd_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rd_imem_pc", imem_pc, 16'h0010);
    step(1'b0, 16'h0, 1'b1);
    chk("rd_out_valid2", {15'd0, out_valid}, 16'd1);
    chk("rd_out_pc", out_pc, 16'h0010);

    // Halt on zero word at 0x0006, then resume via redirect
    mem[3] = 16'h0000;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b1);
    chk("h_out_pc", out_pc, 16'h0006);
    chk("h_out_instr", out_instr, 16'h0000);
    chk("h_halted", {15'd0, halted}, 16'd1);
    chk("h_imem_pc", imem_pc, 16'h0006);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1);
    chk("h_drained", {15'd0, out_valid}, 16'd0);
    chk("h_imem_pc2", imem_pc, 16'h0006);
    step(1'b1, 16'h0000, 1'b1);
    chk("h_resume_halted", {15'd0, halted}, 16'd0);
    chk("h_resume_imem_pc", imem_pc, 16'h0000);
    step(1'b0, 16'h0, 1'b1);
    chk("h_resume_out_pc", out_pc, 16'h0000);
    chk("h_resume_out_instr", out_instr, 16'h1111);
    mem[3] = 16'h4444;

    // Fetch counter: 10 pushes then a redirect
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 1'b1);
    step(1'b1, 16'h0040, 1'b1);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_count", fetch_count, 16'd10);
`else
    chk("perf_count", fetch_count, 16'd0);
`endif

    // Asynchronous reset between edges with the FIFO full
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b0);
    chk("ar_full", {15'd0, out_valid}, 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", {15'd0, out_valid}, 16'd0);
    chk("ar_imem_pc", imem_pc, 16'h0000);
    chk("ar_fetch_count", fetch_count, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_model();

    // Randomized traffic with occasional zero words, redirects and wrap-around targets
    for (int i = 0; i < 32768; i++) begin
      if ($urandom_range(0, 23) == 0) mem[i] = 16'h0000;
    end
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic        rv;
      logic        rdy;
      logic [15:0] rpc;
      int          sel;
      rv  = ($urandom_range(0, 99) < 3);
      rdy = ($urandom_range(0, 99) < 70);
      sel = $urandom_range(0, 3);
      if (sel < 2) rpc = 16'($urandom_range(0, 127));
      else if (sel == 2) rpc = 16'hFFF0 + 16'($urandom_range(0, 15));
      else rpc = 16'($urandom);
      step(rv, rpc, rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
